data_mem_ctrl: RTL and testbench

Parametrised, handshaked successor to the single-cycle data memory: a word-organised RAM behind a valid/ready request port with a configurable wait-state count, byte/halfword/word access, and sign or zero extension on loads. Misaligned and out-of-range accesses are rejected with an error response instead of silently aliasing. A saturating error counter is provided. It sits between the ALU address/store-data path and the write-back mux of the multi-cycle core.

---
 rtl/data_mem_ctrl_if.sv | 29 ++
 rtl/data_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the core datapath and data_mem_ctrl.
// Latency: none (wires only).
// Backpressure: req_ready from the slave; responses are single-cycle pulses with no ready.
// Ports: master drives req_* (except req_ready); slave drives req_ready, resp_*, err_cnt.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [7:0]        err_cnt;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, err_cnt
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, err_cnt
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised data RAM with byte/half/word access, load extension and error responses.
// Latency: valid request responds WAIT_STATES+2 cycles after acceptance; rejected request after 1.
// Backpressure: req_ready high only in IDLE, so one request is in flight at a time.
// Ports: clk, reset (async, active-high), bus (slave side of data_mem_ctrl_if).
module data_mem_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 8192,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [7:0]         err_cnt_q;

    // Request fields captured at the acceptance edge.
    logic               wr_q;
    logic [1:0]         size_q;
    logic               sgn_q;
    logic [1:0]         off_q;
    logic [IDX_W-1:0]   widx_q;
    logic [31:0]        wdata_q;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               req_fire;
    logic               req_bad;
    logic [31:0]        req_widx;
    logic               access_now;
    logic [31:0]        rd_word;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [31:0]        load_val;
    logic [3:0]         be;
    logic [31:0]        wd;

    assign req_fire   = bus.req_valid && (state == IDLE);
    assign req_widx   = 32'(bus.req_addr[ADDR_W-1:2]);
    assign access_now = (state == ACCESS) && (cnt == 4'd0);

    // Illegal size, misalignment and out-of-range word index are all rejected.
    always_comb begin
        req_bad = 1'b0;
        if (bus.req_size == 2'b11)                                 req_bad = 1'b1;
        if (bus.req_size == 2'b01 && bus.req_addr[0])              req_bad = 1'b1;
        if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)   req_bad = 1'b1;
        if (req_widx >= 32'(DEPTH_WORDS))                          req_bad = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = req_bad ? RESP : ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.err_cnt    = err_cnt_q;

    always_ff @(posedge clk) begin
        if (req_fire) begin
            wr_q    <= bus.req_write;
            size_q  <= bus.req_size;
            sgn_q   <= bus.req_signed;
            off_q   <= bus.req_addr[1:0];
            widx_q  <= bus.req_addr[IDX_W+1:2];
            wdata_q <= bus.req_wdata;
        end
    end

    // Load path: pick the lane, right-align, then extend.
    always_comb begin
        rd_word  = mem[widx_q];
        lane_b   = rd_word[{off_q, 3'b000} +: 8];
        lane_h   = off_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (size_q)
            2'b00:   load_val = sgn_q ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
            2'b01:   load_val = sgn_q ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
            default: load_val = rd_word;
        endcase
    end

    // Store path: replicate the right-aligned data across lanes, enable only the addressed ones.
    always_comb begin
        be = 4'b1111;
        wd = wdata_q;
        case (size_q)
            2'b00: begin
                be = 4'b0001 << off_q;
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = off_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
    end

    // Reset forces IDLE asynchronously, so a store still waiting in ACCESS is dropped.
    always_ff @(posedge clk) begin
        if (access_now && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx_q][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        if (req_bad) begin
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        end else begin
                            cnt <= 4'(WAIT_STATES);
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rdata_q <= wr_q ? 32'd0 : load_val;
                        err_q   <= 1'b0;
                    end
                end
                RESP: begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                end
                default: begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (1, 3 and 0 wait states, 16 words each).
// Latency: n/a.
// Backpressure: requests are issued only when the DUT is idle, except in the streaming scenario.
module tb_data_mem_ctrl;
    localparam int WS_A = 1;
    localparam int WS_B = 3;
    localparam int WS_C = 0;
    localparam int DW   = 16;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(16)) bus_a ();
    data_mem_ctrl_if #(.ADDR_W(16)) bus_b ();
    data_mem_ctrl_if #(.ADDR_W(16)) bus_c ();

    data_mem_ctrl #(.ADDR_W(16), .DEPTH_WORDS(DW), .WAIT_STATES(WS_A)) u_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    data_mem_ctrl #(.ADDR_W(16), .DEPTH_WORDS(DW), .WAIT_STATES(WS_B)) u_b (.clk(clk), .reset(rst_b), .bus(bus_b));
    data_mem_ctrl #(.ADDR_W(16), .DEPTH_WORDS(DW), .WAIT_STATES(WS_C)) u_c (.clk(clk), .reset(rst_c), .bus(bus_c));

    // Reference model of instance A: memory image plus error count.
    logic [31:0] mdl [DW];
    int          exp_cnt = 0;

    function automatic bit mdl_err(input logic [1:0] sz, input int ad);
        if (sz == 3) return 1;
        if (sz == 1 && (ad % 2) != 0) return 1;
        if (sz == 2 && (ad % 4) != 0) return 1;
        if (ad / 4 >= DW) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] word, input int ad,
                                             input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        v = word >> ((ad % 4) * 8);
        if (sz == 0) begin
            v = v & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = v & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic mdl_store(input int ad, input logic [1:0] sz, input logic [31:0] d);
        int nb;
        nb = 1 << sz;
        for (int i = 0; i < nb; i++)
            mdl[ad / 4][((ad % 4) + i) * 8 +: 8] = d[i*8 +: 8];
    endtask

    // One request on instance A; lat = -1 if no response arrives in time.
    // resid gathers anything still set in the cycle after the pulse.
    task automatic req_a(input logic w, input logic [1:0] sz, input logic sg, input logic [15:0] ad,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output logic resid);
        @(negedge clk);
        bus_a.req_write = w; bus_a.req_size = sz; bus_a.req_signed = sg;
        bus_a.req_addr = ad; bus_a.req_wdata = wd; bus_a.req_valid = 1'b1;
        @(posedge clk);
        #1 bus_a.req_valid = 1'b0;
        lat = -1; rd = '0; er = 1'b0; resid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus_a.resp_valid === 1'b1) begin
                lat = i; rd = bus_a.resp_rdata; er = bus_a.resp_err;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            resid = bus_a.resp_valid | bus_a.resp_err | (|bus_a.resp_rdata) | ~bus_a.req_ready;
        end
    endtask

    task automatic req_b(input logic w, input logic [15:0] ad, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
        @(negedge clk);
        bus_b.req_write = w; bus_b.req_size = 2'b10; bus_b.req_signed = 1'b0;
        bus_b.req_addr = ad; bus_b.req_wdata = wd; bus_b.req_valid = 1'b1;
        @(posedge clk);
        #1 bus_b.req_valid = 1'b0;
        lat = -1; rd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus_b.resp_valid === 1'b1) begin
                lat = i; rd = bus_b.resp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({bus_a.req_ready, bus_a.resp_valid, bus_a.resp_err} !== 3'b100 || bus_a.resp_rdata !== 32'd0 || bus_a.err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_a: ready/valid/err=%b%b%b rdata=%h cnt=%0d, need 100 0 0",
                     bus_a.req_ready, bus_a.resp_valid, bus_a.resp_err, bus_a.resp_rdata, bus_a.err_cnt);
        end
        n_chk++;
        if ({bus_b.req_ready, bus_b.resp_valid, bus_c.req_ready, bus_c.resp_valid} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_bc: ready/valid b=%b%b c=%b%b, need 10 10",
                     bus_b.req_ready, bus_b.resp_valid, bus_c.req_ready, bus_c.resp_valid);
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; logic er, rs; int lat;
        req_a(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, rd, er, lat, rs);
        mdl_store('h10, 2'b10, 32'hDEADBEEF);
        n_chk++;
        if (lat !== WS_A + 2 || er !== 1'b0 || rd !== 32'd0 || rs !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_resp: lat=%0d err=%b rdata=%h resid=%b, need lat=%0d err=0 rdata=0 resid=0",
                     lat, er, rd, rs, WS_A + 2);
        end
        req_a(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rd, er, lat, rs);
        n_chk++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF || rs !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_resp: lat=%0d err=%b rdata=%h resid=%b, need lat=3 err=0 rdata=deadbeef resid=0",
                     lat, er, rd, rs);
        end
    endtask

    task automatic test_sub_word();
        logic [31:0] rd; logic er, rs; int lat;
        logic [31:0] exp_v [3];
        logic        sg_v  [3];
        logic [1:0]  sz_v  [3];
        logic [15:0] ad_v  [3];
        req_a(1'b1, 2'b00, 1'b0, 16'h0011, 32'h0000007F, rd, er, lat, rs);
        mdl_store('h11, 2'b00, 32'h7F);
        exp_v = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD};
        sg_v  = '{1'b1, 1'b0, 1'b1};
        sz_v  = '{2'b00, 2'b00, 2'b01};
        ad_v  = '{16'h0013, 16'h0013, 16'h0012};
        for (int i = 0; i < 3; i++) begin
            req_a(1'b0, sz_v[i], sg_v[i], ad_v[i], 32'h0, rd, er, lat, rs);
            n_chk++;
            if (rd !== exp_v[i] || rd !== mdl_load(mdl[4], int'(ad_v[i]), sz_v[i], sg_v[i]) || er !== 1'b0 || lat !== 3) begin
                n_fail++;
                $display("FAIL subword_load%0d: rdata=%h err=%b lat=%0d, need rdata=%h err=0 lat=3",
                         i, rd, er, lat, exp_v[i]);
            end
        end
        req_a(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rd, er, lat, rs);
        n_chk++;
        if (rd !== 32'hDEAD7FEF) begin
            n_fail++;
            $display("FAIL sb_merge: word=%h, need dead7fef", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, rs; int lat;
        req_a(1'b1, 2'b01, 1'b0, 16'h0011, 32'h0000AAAA, rd, er, lat, rs);
        exp_cnt++;
        n_chk++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || rs !== 1'b0 || bus_a.err_cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL sh_misaligned: lat=%0d err=%b rdata=%h resid=%b cnt=%0d, need 1 1 0 0 %0d",
                     lat, er, rd, rs, bus_a.err_cnt, exp_cnt);
        end
        req_a(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rd, er, lat, rs);
        n_chk++;
        if (rd !== mdl[4] || er !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_write: word=%h err=%b, need %h err=0", rd, er, mdl[4]);
        end
        req_a(1'b0, 2'b11, 1'b0, 16'h0010, 32'h0, rd, er, lat, rs);
        exp_cnt++;
        n_chk++;
        if (er !== 1'b1 || lat !== 1 || bus_a.err_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL size11: err=%b lat=%0d cnt=%0d, need err=1 lat=1 cnt=2", er, lat, bus_a.err_cnt);
        end
        req_a(1'b0, 2'b10, 1'b0, 16'(4 * DW), 32'h0, rd, er, lat, rs);
        exp_cnt++;
        n_chk++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || bus_a.err_cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL out_of_range: err=%b rdata=%h lat=%0d cnt=%0d, need 1 0 1 %0d",
                     er, rd, lat, bus_a.err_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, ev; logic er, rs, w, sg, ee; int lat, ad, el; logic [1:0] sz;
        for (int i = 0; i < DW; i++) begin
            wd = $urandom;
            req_a(1'b1, 2'b10, 1'b0, 16'(4 * i), wd, rd, er, lat, rs);
            mdl_store(4 * i, 2'b10, wd);
            n_chk++;
            if (er !== 1'b0 || lat !== WS_A + 2) begin
                n_fail++;
                $display("FAIL preload%0d: err=%b lat=%0d, need err=0 lat=%0d", i, er, lat, WS_A + 2);
            end
        end
        for (int i = 0; i < 80; i++) begin
            w  = 1'(($urandom % 2));
            sg = 1'(($urandom % 2));
            sz = 2'($urandom_range(0, 3));
            ad = $urandom_range(0, 4 * DW + 15);
            if (($urandom % 3) != 0 && sz != 3) ad = ad - (ad % (1 << sz));
            wd = $urandom;
            ee = mdl_err(sz, ad);
            el = ee ? 1 : WS_A + 2;
            ev = (ee || w) ? 32'd0 : mdl_load(mdl[ad / 4], ad, sz, sg);
            req_a(w, sz, sg, 16'(ad), wd, rd, er, lat, rs);
            if (ee) exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            else if (w) mdl_store(ad, sz, wd);
            n_chk++;
            if (rd !== ev || er !== ee || lat !== el || rs !== 1'b0 || bus_a.err_cnt !== 8'(exp_cnt)) begin
                n_fail++;
                $display("FAIL rand%0d w=%b sz=%0d sg=%b ad=%h: rdata=%h err=%b lat=%0d resid=%b cnt=%0d, need %h %b %0d 0 %0d",
                         i, w, sz, sg, ad, rd, er, lat, rs, bus_a.err_cnt, ev, ee, el, exp_cnt);
            end
        end
        // Every word read back against the model catches lanes written by mistake.
        for (int i = 0; i < DW; i++) begin
            req_a(1'b0, 2'b10, 1'b0, 16'(4 * i), 32'h0, rd, er, lat, rs);
            n_chk++;
            if (rd !== mdl[i] || er !== 1'b0) begin
                n_fail++;
                $display("FAIL readback%0d: word=%h err=%b, need %h err=0", i, rd, er, mdl[i]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [31:0] rd; logic er, rs; int lat;
        for (int i = 0; i < 260; i++) begin
            req_a(1'b0, 2'b11, 1'b0, 16'h0000, 32'h0, rd, er, lat, rs);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            n_chk++;
            if (bus_a.err_cnt !== 8'(exp_cnt) || er !== 1'b1) begin
                n_fail++;
                $display("FAIL sat%0d: cnt=%0d err=%b, need cnt=%0d err=1", i, bus_a.err_cnt, er, exp_cnt);
            end
        end
        n_chk++;
        if (bus_a.err_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_final: cnt=%0d, need 255", bus_a.err_cnt);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; int lat;
        req_b(1'b1, 16'h0008, 32'h11223344, rd, lat);
        n_chk++;
        if (lat !== WS_B + 2) begin
            n_fail++;
            $display("FAIL b_store_lat: lat=%0d, need %0d", lat, WS_B + 2);
        end
        @(negedge clk);
        @(negedge clk);
        bus_b.req_write = 1'b1; bus_b.req_addr = 16'h0008; bus_b.req_wdata = 32'hCAFEF00D;
        bus_b.req_size = 2'b10; bus_b.req_valid = 1'b1;
        @(posedge clk);
        #1 bus_b.req_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus_b.req_ready !== 1'b0 || bus_b.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b_in_access: ready=%b valid=%b, need 0 0", bus_b.req_ready, bus_b.resp_valid);
        end
        @(posedge clk);
        #2 rst_b = 1'b1;
        #1;
        n_chk++;
        if ({bus_b.req_ready, bus_b.resp_valid, bus_b.resp_err} !== 3'b100 || bus_b.resp_rdata !== 32'd0 || bus_b.err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL b_async_reset: ready/valid/err=%b%b%b rdata=%h cnt=%0d, need 100 0 0",
                     bus_b.req_ready, bus_b.resp_valid, bus_b.resp_err, bus_b.resp_rdata, bus_b.err_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_b = 1'b0;
            n_chk++;
            if (bus_b.resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b_no_resp%0d: resp_valid=%b, need 0", i, bus_b.resp_valid);
            end
        end
        req_b(1'b0, 16'h0008, 32'h0, rd, lat);
        n_chk++;
        if (rd !== 32'h11223344 || lat !== WS_B + 2) begin
            n_fail++;
            $display("FAIL b_store_abandoned: word=%h lat=%0d, need 11223344 lat=%0d", rd, lat, WS_B + 2);
        end
    endtask

    task automatic test_back_to_back();
        int per, n_rdy, n_resp;
        per = WS_C + 3;
        n_rdy = 0; n_resp = 0;
        @(negedge clk);
        bus_c.req_write = 1'b1; bus_c.req_size = 2'b10; bus_c.req_signed = 1'b0;
        bus_c.req_addr = 16'h0004; bus_c.req_wdata = 32'h5A5A5A5A; bus_c.req_valid = 1'b1;
        for (int k = 0; k < 10 * per; k++) begin
            if (k != 0) @(negedge clk);
            n_rdy  += (bus_c.req_ready === 1'b1) ? 1 : 0;
            n_resp += (bus_c.resp_valid === 1'b1) ? 1 : 0;
            n_chk++;
            if (bus_c.req_ready !== ((k % per) == 0) || bus_c.resp_valid !== ((k % per) == per - 1)) begin
                n_fail++;
                $display("FAIL stream_cycle%0d: ready=%b valid=%b, need %b %b", k,
                         bus_c.req_ready, bus_c.resp_valid, (k % per) == 0, (k % per) == per - 1);
            end
        end
        @(negedge clk);
        bus_c.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_resp += (bus_c.resp_valid === 1'b1) ? 1 : 0;
        end
        n_chk++;
        if (n_rdy !== 10 || n_resp !== 10) begin
            n_fail++;
            $display("FAIL stream_counts: accepts=%0d responses=%0d, need 10 10", n_rdy, n_resp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_size = 2'b00;
        bus_a.req_signed = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
        bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_size = 2'b00;
        bus_b.req_signed = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
        bus_c.req_valid = 1'b0; bus_c.req_write = 1'b0; bus_c.req_size = 2'b00;
        bus_c.req_signed = 1'b0; bus_c.req_addr = '0; bus_c.req_wdata = '0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        test_reset();
        test_word_rw();
        test_sub_word();
        test_errors();
        test_random();
        test_saturate();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
